// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types, coin codes and credit helpers for the vending FSM
package vending_pkg;

    localparam int PRICE = 20;

    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2,
        S15 = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Credit held by a state, in money units.
    function automatic logic [5:0] credit_of(input state_t s);
        case (s)
            S5:      credit_of = 6'd5;
            S10:     credit_of = 6'd10;
            S15:     credit_of = 6'd15;
            default: credit_of = 6'd0;
        endcase
    endfunction

    // Value of a coin code; none and invalid both add nothing.
    function automatic logic [5:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_5:  coin_value = 6'd5;
            COIN_10: coin_value = 6'd10;
            default: coin_value = 6'd0;
        endcase
    endfunction

    // State that holds a given partial credit (only called below PRICE).
    function automatic state_t state_of(input logic [5:0] credit);
        case (credit)
            6'd5:    state_of = S5;
            6'd10:   state_of = S10;
            6'd15:   state_of = S15;
            default: state_of = S0;
        endcase
    endfunction

endpackage

// File: rtl/vending_sale_counter.sv
// rtl/vending_sale_counter.sv - wrapping count of completed sales
module vending_sale_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one sale per edge with inc high; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vending_mealy.sv
// rtl/vending_mealy.sv - Mealy vending FSM, price 20; sale counter under VEND_SALE_CNT_EN
module vending_mealy
    import vending_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       coin,
    output logic             dispense,
`ifdef VEND_SALE_CNT_EN
    output logic [CNT_W-1:0] sale_count,
`endif
    output logic             chg5
);

    state_t     state;
    state_t     state_next;
    logic [5:0] total;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // Credit register; reset drops any partial credit immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // Mealy outputs and next credit; a sale always returns to S0 so no credit carries over.
    always_comb begin
        state_next = state;
        dispense   = 1'b0;
        chg5       = 1'b0;
        total      = credit_of(state) + coin_value(coin);
        if (!rst && coin_value(coin) != 6'd0) begin
            if (total >= 6'(PRICE)) begin
                dispense   = 1'b1;
                chg5       = (total == 6'(PRICE + 5));
                state_next = S0;
            end else begin
                state_next = state_of(total);
            end
        end
    end

`ifdef VEND_SALE_CNT_EN
    vending_sale_counter #(
        .CNT_W (CNT_W)
    ) u_sale_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (dispense),
        .count (sale_count)
    );
`endif

endmodule

// File: tb/tb_vending_mealy.sv
// tb/tb_vending_mealy.sv - randomized and directed check of vending_mealy against a credit model
module tb_vending_mealy;
    import vending_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       coin;
    logic             dispense;
    logic             chg5;
`ifdef VEND_SALE_CNT_EN
    logic [CNT_W-1:0] sale_count;
`endif

    int tests;
    int fails;
    int credit;
    int sales;

    vending_mealy #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .dispense   (dispense),
`ifdef VEND_SALE_CNT_EN
        .sale_count (sale_count),
`endif
        .chg5       (chg5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int state_credit(input state_t s);
        case (s)
            S0:      return 0;
            S5:      return 5;
            S10:     return 10;
            S15:     return 15;
            default: return -1;
        endcase
    endfunction

    task automatic check_state(input string tag);
        check(tag, state_credit(dut.state), credit);
`ifdef VEND_SALE_CNT_EN
        check({tag, "_count"}, int'(sale_count), sales);
`endif
    endtask

    // One coin for one rising edge: outputs checked before the edge, credit after.
    task automatic step(input logic [1:0] c, input string tag);
        int v;
        int total;
        int exp_d;
        int exp_c;
        @(negedge clk);
        coin = c;
        #1;
        v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
        total = credit + v;
        exp_d = (v != 0 && total >= 20) ? 1 : 0;
        exp_c = (v != 0 && total == 25) ? 1 : 0;
        check({tag, "_dispense"}, int'(dispense), exp_d);
        check({tag, "_chg5"}, int'(chg5), exp_c);
        @(posedge clk);
        #1;
        coin = 2'b00;
        if (exp_d == 1) begin
            credit = 0;
            sales  = (sales + 1) % (1 << CNT_W);
        end else begin
            credit = total;
        end
        check_state({tag, "_state"});
    endtask

    // Reset pulse between edges while a ten is presented; outputs must stay low.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        coin = 2'b10;
        rst  = 1'b1;
        #1;
        credit = 0;
        sales  = 0;
        check({tag, "_dispense"}, int'(dispense), 0);
        check({tag, "_chg5"}, int'(chg5), 0);
        check_state({tag, "_state"});
        #1;
        rst  = 1'b0;
        coin = 2'b00;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        credit = 0;
        sales  = 0;
        coin   = 2'b00;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dispense", int'(dispense), 0);
        check("reset_chg5", int'(chg5), 0);
        check_state("reset_state");
        rst = 1'b0;

        step(2'b01, "a1"); step(2'b10, "a2"); step(2'b01, "a3");
        step(2'b10, "b1"); step(2'b10, "b2");
        step(2'b01, "c1"); step(2'b10, "c2"); step(2'b10, "c3");
        step(2'b01, "d1"); step(2'b11, "d2"); step(2'b11, "d3"); step(2'b10, "d4");
        step(2'b01, "d5");
        step(2'b10, "e1");
        async_reset("e_rst");
        step(2'b10, "e2");
        step(2'b00, "e3");
        step(2'b10, "e4");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step(2'($urandom_range(0, 3)), "rnd");
            end
        end

        async_reset("w_rst");
        for (int i = 0; i < 3; i++) begin
            step(2'b10, "w3a"); step(2'b10, "w3b");
        end
        for (int i = 0; i < 253; i++) begin
            step(2'b10, "wa"); step(2'b10, "wb");
        end
        step(2'b01, "wrap_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
